nt_reward_predictor: RTL and testbench

- Sequential reward-prediction-error (RPE) stage directly upstream of the dopamine resource counter; its inc/dec/fast outputs drive that counter's step inputs.
- A trial opens when a new action appears and watches stimuli for reward or punishment over a bounded window.
- It compares the outcome with a learned per-action expectation, emits an inc or dec pulse burst sized by the error, then nudges the expectation toward the outcome.

---
 rtl/nt_reward_predictor_pkg.sv | 34 +++
 rtl/nt_reward_predictor_if.sv | 20 ++
 rtl/nt_expectation_table.sv | 31 +++
 rtl/nt_reward_predictor.sv | 138 +++++++++++++
 tb/tb_nt_reward_predictor.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nt_reward_predictor_pkg.sv
// Shared encodings and helpers for the reward-prediction-error stage.
package nt_reward_predictor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      BURST  = 2'd2,
      UPDATE = 2'd3
   } state_t;

   localparam int EXP_W = 3;
   typedef logic [EXP_W-1:0] exp_t;

   localparam exp_t OUTCOME_REWARD = 3'd7;
   localparam exp_t OUTCOME_NONE   = 3'd0;

   function automatic logic [2:0] low_index(input logic [7:0] v);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   function automatic exp_t step_toward(input exp_t cur, input exp_t tgt);
      exp_t r;
      r = cur;
      if (cur < tgt) r = cur + 3'd1;
      else if (cur > tgt) r = cur - 3'd1;
      return r;
   endfunction

endpackage

// File: rtl/nt_reward_predictor_if.sv
// Stimulus/action inputs and dopamine step outputs of the RPE stage.
interface nt_reward_predictor_if;
   logic        tick;
   logic [15:0] stimuli;
   logic [7:0]  action;
   logic        inc;
   logic        dec;
   logic        fast;
   logic        busy;

   modport master (
      output tick, stimuli, action,
      input  inc, dec, fast, busy
   );

   modport slave (
      input  tick, stimuli, action,
      output inc, dec, fast, busy
   );
endinterface

// File: rtl/nt_expectation_table.sv
// 8x3 per-action expectation file; decay input is driven only when
// NT_RPE_HABITUATION_EN is defined in the parent.
module nt_expectation_table
   import nt_reward_predictor_pkg::*;
#(
   parameter int EXP_INIT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] idx,
   output exp_t       rdata,
   input  logic       we,
   input  exp_t       target,
   input  logic       decay
);
   localparam exp_t INIT = exp_t'(EXP_INIT);

   exp_t mem [8];

   assign rdata = mem[idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= INIT;
      end else if (we) begin
         mem[idx] <= step_toward(mem[idx], target);
      end else if (decay) begin
         for (int i = 0; i < 8; i++) mem[i] <= step_toward(mem[i], INIT);
      end
   end
endmodule

// File: rtl/nt_reward_predictor.sv
// Reward-prediction-error stage feeding the dopamine resource counter.
// Optional habituation decay of idle expectations: NT_RPE_HABITUATION_EN.
module nt_reward_predictor
   import nt_reward_predictor_pkg::*;
#(
   parameter logic [15:0] REWARD_MASK = 16'h00F0,
   parameter logic [15:0] PUNISH_MASK = 16'h0F00,
   parameter int WINDOW      = 6,
   parameter int EXP_INIT    = 3,
   parameter int FAST_THRESH = 4
`ifdef NT_RPE_HABITUATION_EN
  ,parameter int DECAY_TICKS = 32
`endif
) (
   input logic clk,
   input logic rst_n,
   nt_reward_predictor_if.slave bus
);
   localparam logic [3:0] WIN_INIT = 4'(WINDOW);
   localparam logic [3:0] FAST_MIN = 4'(FAST_THRESH);

   state_t            state;
   state_t            state_nx;
   logic [7:0]        action_prev;
   logic [3:0]        win;
   logic [2:0]        idx;
   logic [2:0]        burst;
   exp_t              outcome;
   logic              dir;
   logic              fst;
   logic              rwd;
   logic              pun;
   logic              trig;
   logic              hit;
   logic              pulse;
   logic              upd;
   logic              decay;
   exp_t              e_cur;
   exp_t              out_val;
   logic signed [3:0] err;
   logic [2:0]        mag;

   assign rwd     = |(bus.stimuli & REWARD_MASK);
   assign pun     = |(bus.stimuli & PUNISH_MASK);
   assign trig    = (bus.action != 8'h00) && (action_prev == 8'h00);
   assign hit     = pun | rwd | (win == 4'd1);
   assign out_val = (rwd & ~pun) ? OUTCOME_REWARD : OUTCOME_NONE;
   assign err     = $signed({1'b0, out_val}) - $signed({1'b0, e_cur});
   assign mag     = err[3] ? 3'(-err) : err[2:0];
   assign upd     = (state == UPDATE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.tick && trig) state_nx = WAIT;
         WAIT:    if (bus.tick && hit)
                     state_nx = (err == 4'sd0) ? IDLE : BURST;
         BURST:   if (bus.tick && burst == 3'd1) state_nx = UPDATE;
         UPDATE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A reset cycle swallows any pulse the burst would have emitted
   always_comb begin
      pulse    = (state == BURST) & bus.tick & rst_n;
      bus.inc  = pulse & dir;
      bus.dec  = pulse & ~dir;
      bus.fast = pulse & fst;
      bus.busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         action_prev <= '0;
         win         <= '0;
         idx         <= '0;
         burst       <= '0;
         outcome     <= OUTCOME_NONE;
         dir         <= 1'b0;
         fst         <= 1'b0;
      end else begin
         if (bus.tick) action_prev <= bus.action;
         unique case (state)
            IDLE: if (bus.tick && trig) begin
               idx <= low_index(bus.action);
               win <= WIN_INIT;
            end
            WAIT: if (bus.tick) begin
               if (hit) begin
                  outcome <= out_val;
                  burst   <= mag;
                  dir     <= ~err[3];
                  fst     <= ({1'b0, mag} >= FAST_MIN) | pun;
               end else begin
                  win <= win - 4'd1;
               end
            end
            BURST: if (bus.tick) burst <= burst - 3'd1;
            default: ;
         endcase
      end
   end

`ifdef NT_RPE_HABITUATION_EN
   localparam logic [5:0] IDLE_LAST = 6'(DECAY_TICKS - 1);
   logic [5:0] idle_cnt;

   assign decay = (state == IDLE) && bus.tick && !trig &&
                  (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) idle_cnt <= '0;
      else if (state != IDLE) idle_cnt <= '0;
      else if (bus.tick && (trig || decay)) idle_cnt <= '0;
      else if (bus.tick) idle_cnt <= idle_cnt + 6'd1;
   end
`else
   assign decay = 1'b0;
`endif

   nt_expectation_table #(
      .EXP_INIT(EXP_INIT)
   ) u_table (
      .clk    (clk),
      .rst_n  (rst_n),
      .idx    (idx),
      .rdata  (e_cur),
      .we     (upd),
      .target (outcome),
      .decay  (decay)
   );
endmodule

// File: tb/tb_nt_reward_predictor.sv
// Bench for nt_reward_predictor: vector table, corner sequences, random vs model.
module tb_nt_reward_predictor;
   localparam int WIN = 6;
   localparam int EI  = 3;
   localparam int FT  = 4;
   localparam int DT  = 32;
`ifdef NT_RPE_HABITUATION_EN
   localparam int HAB_E = 4;
`else
   localparam int HAB_E = 5;
`endif

   typedef struct packed {
      logic inc;
      logic dec;
      logic fast;
   } pulse_t;

   typedef struct {
      bit          tk;
      logic [15:0] st;
      logic [7:0]  act;
      bit          rs;
      logic [3:0]  want;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   nt_reward_predictor_if bus();

   nt_reward_predictor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int     m_e [8];
   bit     m_trial;
   bit     m_upd;
   int     m_win;
   int     m_idx;
   int     m_out;
   int     m_prev;
   int     m_idle;
   pulse_t m_q [$];

   vec_t       tbl [$];
   logic [3:0] got;
   logic [3:0] mdl;

   task automatic check(input string name, input logic [31:0] a,
                        input logic [31:0] w);
      n_cmp++;
      if (a !== w) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, a, w);
      end
   endtask

   function automatic int toward(int c, int t);
      return (c < t) ? c + 1 : (c > t) ? c - 1 : c;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_e[i] = EI;
      m_trial = 0;
      m_upd   = 0;
      m_win   = 0;
      m_idx   = 0;
      m_out   = 0;
      m_prev  = 0;
      m_idle  = 0;
      m_q.delete();
   endfunction

   function automatic bit model_busy();
      return m_trial || (m_q.size() != 0) || m_upd;
   endfunction

   function automatic logic [3:0] model_out(bit tk, bit rs);
      logic [3:0] r;
      r = {3'b000, model_busy()};
      if (rs && tk && !m_upd && m_q.size() != 0) r[3:1] = m_q[0];
      return r;
   endfunction

   // Trial-level model: a queue of pending pulses stands in for the burst
   function automatic void model_edge(bit tk, logic [15:0] st,
                                      logic [7:0] act, bit rs);
      int err;
      int mag;
      bit pun;
      bit rwd;
      if (!rs) begin
         model_reset();
         return;
      end
      pun = (st & 16'h0F00) != 0;
      rwd = (st & 16'h00F0) != 0;
      if (m_upd) begin
         m_e[m_idx] = toward(m_e[m_idx], m_out);
         m_upd = 0;
      end else if (tk) begin
         if (m_q.size() != 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_upd = 1;
         end else if (m_trial) begin
            if (pun || rwd || m_win == 1) begin
               m_out = (rwd && !pun) ? 7 : 0;
               err = m_out - m_e[m_idx];
               mag = (err < 0) ? -err : err;
               m_trial = 0;
               for (int k = 0; k < mag; k++)
                  m_q.push_back('{inc: err > 0, dec: err < 0,
                                  fast: (mag >= FT) || pun});
            end else begin
               m_win--;
            end
         end else if (act != 0 && m_prev == 0) begin
            m_trial = 1;
            m_win   = WIN;
            m_idle  = 0;
            m_idx   = 0;
            while (!act[m_idx]) m_idx++;
         end else begin
`ifdef NT_RPE_HABITUATION_EN
            m_idle++;
            if (m_idle == DT) begin
               for (int i = 0; i < 8; i++) m_e[i] = toward(m_e[i], EI);
               m_idle = 0;
            end
`endif
         end
      end
      if (tk) m_prev = int'(act);
   endfunction

   function automatic logic [3:0] mask_fast(logic [3:0] v, logic [3:0] r);
      logic [3:0] o;
      o = v;
      if (!r[3] && !r[2]) o[1] = 1'b0;
      return o;
   endfunction

   task automatic step(input bit tk, input logic [15:0] st,
                       input logic [7:0] act, input bit rs, input bit chk);
      @(negedge clk);
      bus.tick    = tk;
      bus.stimuli = st;
      bus.action  = act;
      rst_n       = rs;
      #1;
      got = {bus.inc, bus.dec, bus.fast, bus.busy};
      mdl = model_out(tk, rs);
      if (chk) check("model", mask_fast(got, mdl), mdl);
      @(posedge clk);
      model_edge(tk, st, act, rs);
   endtask

   task automatic check_e();
      for (int i = 0; i < 8; i++)
         check($sformatf("E%0d", i), dut.u_table.mem[i], m_e[i]);
   endtask

   task automatic run_trial(input logic [7:0] act, input logic [15:0] st,
                            output int npulse, output int nbusy);
      int guard;
      npulse = 0;
      nbusy  = 0;
      guard  = 0;
      step(1, 16'h0, 8'h00, 1, 1);
      step(1, 16'h0, act, 1, 1);
      step(1, st, act, 1, 1);
      while (model_busy() && guard < 40) begin
         step(1, 16'h0, act, 1, 1);
         guard++;
         if (got[3] | got[2]) npulse++;
         if (got[0]) nbusy++;
      end
      check("trial_bound", guard < 40, 1);
      step(1, 16'h0, act, 1, 1);
   endtask

   function automatic void add(int n, bit tk, logic [15:0] st,
                               logic [7:0] a, bit rs, logic [3:0] w);
      for (int k = 0; k < n; k++) tbl.push_back('{tk, st, a, rs, w});
   endfunction

   initial begin
      int np;
      int nb;
      int inc_on;
      int inc_off;
      bit tk;
      logic [15:0] st;
      logic [7:0]  act;
      int r;

      bus.tick    = 1'b0;
      bus.stimuli = '0;
      bus.action  = '0;
      rst_n       = 1'b0;
      model_reset();
      step(1, 16'h0, 8'h00, 0, 0);
      step(1, 16'h0, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++)
         check($sformatf("rst_E%0d", i), dut.u_table.mem[i], EI);

      // {inc,dec,fast,busy}
      add(1, 1, 16'h0000, 8'h00, 1, 4'b0000);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0000);
      add(1, 1, 16'h0010, 8'h01, 1, 4'b0001);
      add(4, 1, 16'h0000, 8'h01, 1, 4'b1011);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0001);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0000);
      add(1, 1, 16'h0000, 8'h00, 0, 4'b0000);
      add(1, 1, 16'h0000, 8'h00, 1, 4'b0000);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0000);
      add(6, 1, 16'h0000, 8'h01, 1, 4'b0001);
      add(3, 1, 16'h0000, 8'h01, 1, 4'b0101);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0001);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0000);
      add(1, 1, 16'h0000, 8'h00, 1, 4'b0000);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0000);
      add(1, 1, 16'h0110, 8'h01, 1, 4'b0001);
      add(2, 1, 16'h0000, 8'h01, 1, 4'b0111);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0001);
      add(1, 1, 16'h0000, 8'h01, 1, 4'b0000);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].tk, tbl[i].st, tbl[i].act, tbl[i].rs, 0);
         check($sformatf("vec%0d", i), mask_fast(got, tbl[i].want),
               tbl[i].want);
      end
      check("E0_table", dut.u_table.mem[0], 1);
      check_e();

      // saturate E[2] at 7, then a zero-error trial
      step(1, 16'h0, 8'h00, 0, 1);
      for (int t = 0; t < 4; t++) begin
         run_trial(8'h04, 16'h0010, np, nb);
         if (t == 0) begin
            check("first_pulses", np, 4);
            check("first_busy", nb, 5);
         end
      end
      check("E2_sat", dut.u_table.mem[2], 7);
      run_trial(8'h04, 16'h0010, np, nb);
      check("zero_err_pulses", np, 0);
      check("zero_err_busy", nb, 0);
      check("zero_err_idle", got[0], 0);
      check("E2_hold", dut.u_table.mem[2], 7);

      // sparse ticks during a burst, then reset mid-burst
      step(1, 16'h0, 8'h00, 0, 1);
      step(1, 16'h0, 8'h00, 1, 1);
      step(1, 16'h0, 8'h01, 1, 1);
      step(1, 16'h0010, 8'h01, 1, 1);
      inc_on  = 0;
      inc_off = 0;
      for (int c = 0; c < 8; c++) begin
         tk = (c % 4 == 3);
         step(tk, 16'h0, 8'h01, 1, 1);
         if (got[3]) begin
            if (tk) inc_on++;
            else inc_off++;
         end
      end
      check("slow_inc_off", inc_off, 0);
      check("slow_inc_on", inc_on, 2);
      step(1, 16'h0, 8'h01, 0, 1);
      check("rst_pulse_drop", got[3:2], 0);
      step(0, 16'h0, 8'h01, 1, 1);
      check("rst_mid_out", {got[3], got[2], got[0]}, 0);
      for (int i = 0; i < 8; i++)
         check($sformatf("rst_mid_E%0d", i), dut.u_table.mem[i], EI);

      // habituation: E[0]=5 then 32 idle ticks
      step(1, 16'h0, 8'h00, 0, 1);
      run_trial(8'h01, 16'h0010, np, nb);
      run_trial(8'h01, 16'h0010, np, nb);
      check("hab_E0_pre", dut.u_table.mem[0], 5);
      repeat (30) step(1, 16'h0, 8'h00, 1, 1);
      check("hab_E0_31", dut.u_table.mem[0], 5);
      step(1, 16'h0, 8'h00, 1, 1);
      check("hab_E0_32", dut.u_table.mem[0], HAB_E);

      // randomized traffic against the model
      step(1, 16'h0, 8'h00, 0, 1);
      act = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         tk = ($urandom_range(0, 3) != 0);
         st = 16'($urandom) & 16'hF00F;
         r  = $urandom_range(0, 19);
         if (r < 3) st = st | (16'h0010 << $urandom_range(0, 3));
         if (r == 0 || r == 3) st = st | (16'h0100 << $urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0)
            act = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
         step(tk, st, act, $urandom_range(0, 299) != 0, 1);
      end
      check_e();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
